// File: rtl/scan_seq.sv
// scan_seq: steps a 5-bit decoder address from first to last (either direction,
// wrapping modulo 32). Each address is held for dwell+1 cycles, and the scan ends
// with a one-cycle done pulse, or with a one-cycle aborted pulse if stop is applied.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; A holds its last value, en/busy low
// SCAN  | address valid on A, en/busy high, dwell counter running
// FIN   | one-cycle completion state, done high, A holds last address

module scan_seq #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic [4:0]         first,
    input  logic [4:0]         last,
    input  logic [DWELL_W-1:0] dwell,
    output logic [4:0]         A,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [4:0]         a_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               busy_nxt, done_nxt, aborted_nxt;
    logic [4:0]         lat_last, lat_last_nxt;
    logic [DWELL_W-1:0] lat_dwell, lat_dwell_nxt;
    logic               lat_dir, lat_dir_nxt;

    // State and registered outputs; en and busy share one next value so they never differ.
    // The first address needs no separate register: it is loaded straight into A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            A         <= '0;
            en        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            cnt       <= '0;
            lat_last  <= '0;
            lat_dwell <= '0;
            lat_dir   <= 1'b0;
        end else begin
            state     <= state_nxt;
            A         <= a_nxt;
            en        <= busy_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            aborted   <= aborted_nxt;
            cnt       <= cnt_nxt;
            lat_last  <= lat_last_nxt;
            lat_dwell <= lat_dwell_nxt;
            lat_dir   <= lat_dir_nxt;
        end
    end

    // Next-state, datapath and pulse generation.
    always_comb begin
        state_nxt     = state;
        a_nxt         = A;
        cnt_nxt       = cnt;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        aborted_nxt   = 1'b0;
        lat_last_nxt  = lat_last;
        lat_dwell_nxt = lat_dwell;
        lat_dir_nxt   = lat_dir;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    lat_last_nxt  = last;
                    lat_dwell_nxt = dwell;
                    lat_dir_nxt   = dir;
                    a_nxt         = first;
                    cnt_nxt       = dwell;
                    busy_nxt      = 1'b1;
                    state_nxt     = SCAN;
                end
            end
            SCAN: begin
                // stop takes priority over the final expiry
                if (stop) begin
                    busy_nxt    = 1'b0;
                    aborted_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (A != lat_last) begin
                    a_nxt   = lat_dir ? (A - 5'd1) : (A + 5'd1);
                    cnt_nxt = lat_dwell;
                end else begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_seq.sv
// Testbench for scan_seq: directed cases plus randomized scans checked against an
// address-list model computed from first/last/dir/dwell.

module tb_scan_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic [4:0] first = '0;
    logic [4:0] last = '0;
    logic [3:0] dwell = '0;
    logic [4:0] A;
    logic       en, busy, done, aborted;

    int errors = 0;
    int checks = 0;

    scan_seq #(.DWELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
        .first(first), .last(last), .dwell(dwell),
        .A(A), .en(en), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_quiet(input string tag, input logic [4:0] exp_a);
        chk({tag, " en"}, {31'd0, en}, 32'd0);
        chk({tag, " busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " done"}, {31'd0, done}, 32'd0);
        chk({tag, " aborted"}, {31'd0, aborted}, 32'd0);
        chk({tag, " A"}, {27'd0, A}, {27'd0, exp_a});
    endtask

    // Model: the scan visits N addresses, index k/(dwell+1) away from first.
    function automatic int addr_at(int f, int d, int dw, int k);
        int idx = k / (dw + 1);
        return d ? ((f - idx + 64) % 32) : ((f + idx) % 32);
    endfunction

    function automatic int n_addr(int f, int l, int d);
        return d ? (((f - l + 32) % 32) + 1) : (((l - f + 32) % 32) + 1);
    endfunction

    // Runs one scan; stop_at = SCAN cycle index where stop is raised (-1 = never).
    // poke pulses start during SCAN and FIN, and inputs are scrambled after start.
    task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input logic [3:0] dw,
                            input logic d, input int stop_at, input bit poke);
        int total;
        int ea;
        int ens;
        total = n_addr(int'(f), int'(l), int'(d)) * (int'(dw) + 1);
        ens = 0;
        @(negedge clk);
        first = f; last = l; dwell = dw; dir = d; start = 1'b1; stop = 1'b0;
        @(negedge clk);
        start = 1'b0;
        first = 5'($urandom); last = 5'($urandom); dwell = 4'($urandom); dir = 1'($urandom);
        for (int k = 0; k < total; k++) begin
            ea = addr_at(int'(f), int'(d), int'(dw), k);
            chk("scan A", {27'd0, A}, ea);
            chk("scan en", {31'd0, en}, 32'd1);
            chk("scan busy", {31'd0, busy}, 32'd1);
            chk("scan done", {31'd0, done}, 32'd0);
            chk("scan aborted", {31'd0, aborted}, 32'd0);
            if (en === 1'b1) ens++;
            if (k == stop_at) stop = 1'b1;
            if (poke && k == 1) start = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            start = 1'b0;
            if (k == stop_at) begin
                chk("abort pulse", {31'd0, aborted}, 32'd1);
                chk("abort done", {31'd0, done}, 32'd0);
                chk("abort en", {31'd0, en}, 32'd0);
                chk("abort busy", {31'd0, busy}, 32'd0);
                chk("abort A", {27'd0, A}, ea);
                @(negedge clk);
                chk_idle_quiet("post abort", 5'(ea));
                return;
            end
        end
        chk("en cycles", ens, total);
        chk("fin done", {31'd0, done}, 32'd1);
        chk("fin aborted", {31'd0, aborted}, 32'd0);
        chk("fin en", {31'd0, en}, 32'd0);
        chk("fin busy", {31'd0, busy}, 32'd0);
        chk("fin A", {27'd0, A}, {27'd0, l});
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_idle_quiet("post fin", l);
    endtask

    initial begin
        int f, l, dw, d, sa, tot;
        // reset state
        #12;
        chk_idle_quiet("reset", 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_scan(5'd3, 5'd6, 4'd1, 1'b0, -1, 1'b0);
        run_scan(5'd30, 5'd1, 4'd0, 1'b0, -1, 1'b0);
        run_scan(5'd1, 5'd30, 4'd0, 1'b1, -1, 1'b0);
        run_scan(5'd17, 5'd17, 4'd3, 1'b0, -1, 1'b0);
        run_scan(5'd0, 5'd7, 4'd0, 1'b0, 2, 1'b0);
        run_scan(5'd4, 5'd6, 4'd2, 1'b0, 8, 1'b0);
        run_scan(5'd10, 5'd5, 4'd1, 1'b1, -1, 1'b1);

        // start and stop together in IDLE do nothing
        @(negedge clk);
        start = 1'b1; stop = 1'b1; first = 5'd9; last = 5'd12;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk_idle_quiet("start+stop idle", 5'd5);
        @(negedge clk);
        chk_idle_quiet("start+stop idle2", 5'd5);

        // asynchronous reset mid-scan
        @(negedge clk);
        first = 5'd0; last = 5'd20; dwell = 4'd2; dir = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_idle_quiet("async reset", 5'd0);
        repeat (2) @(negedge clk);
        chk_idle_quiet("held reset", 5'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_idle_quiet("after reset", 5'd0);
        run_scan(5'd2, 5'd4, 4'd0, 1'b0, -1, 1'b0);

        // randomized scans
        for (int i = 0; i < 24; i++) begin
            f = int'($urandom_range(0, 31));
            l = int'($urandom_range(0, 31));
            dw = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 1));
            tot = n_addr(f, l, d) * (dw + 1);
            if (tot > 120) dw = 0;
            tot = n_addr(f, l, d) * (dw + 1);
            sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, tot - 1)) : -1;
            run_scan(5'(f), 5'(l), 4'(dw), 1'(d), sa, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
